// File: rtl/aes_128_encrypt_iter_if.sv
// Handshake and data bundle between a requester and the iterative AES-128 core.
// The round keys travel with the request because the key schedule drives them combinationally.
interface aes_128_encrypt_iter_if;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] sk0;
  logic [127:0] sk1;
  logic [127:0] sk2;
  logic [127:0] sk3;
  logic [127:0] sk4;
  logic [127:0] sk5;
  logic [127:0] sk6;
  logic [127:0] sk7;
  logic [127:0] sk8;
  logic [127:0] sk9;
  logic [127:0] sk10;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;

  modport master (
    output start, plaintext,
    output sk0, sk1, sk2, sk3, sk4, sk5, sk6, sk7, sk8, sk9, sk10,
    input  busy, done, ciphertext
  );

  modport slave (
    input  start, plaintext,
    input  sk0, sk1, sk2, sk3, sk4, sk5, sk6, sk7, sk8, sk9, sk10,
    output busy, done, ciphertext
  );
endinterface

// File: rtl/aes_128_encrypt_iter.sv
// Iterative AES-128 encryption: one round per clock, ten clocks per block.
// Contains the byte S-box used sixteen times for SubBytes.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];
endmodule

module aes_128_encrypt_iter (
  input logic                   clk,
  input logic                   rst_n,
  aes_128_encrypt_iter_if.slave bus
);
  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm;
  fsm_t         fsm_nxt;
  logic [127:0] state_q;
  logic [3:0]   rnd;
  logic         done_q;
  logic [127:0] ct_q;
  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [127:0] rkey;
  logic         accept;
  logic         advance;
  logic         finish;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k of a block sits at [127-8k -: 8]; k = 4*column + row.
  for (genvar k = 0; k < 16; k++) begin : g_sub
    aes_sbox u_sbox (
      .a(state_q[127-8*k -: 8]),
      .y(sb[127-8*k -: 8])
    );
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;

    // Row r of column c takes the byte from column (c+r) mod 4.
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    end

    assign a0 = sr[127-8*(4*c)   -: 8];
    assign a1 = sr[127-8*(4*c+1) -: 8];
    assign a2 = sr[127-8*(4*c+2) -: 8];
    assign a3 = sr[127-8*(4*c+3) -: 8];

    assign mc[127-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // Unreachable counter values fall back to sk0.
  always_comb begin
    rkey = bus.sk0;
    case (rnd)
      4'd1:    rkey = bus.sk1;
      4'd2:    rkey = bus.sk2;
      4'd3:    rkey = bus.sk3;
      4'd4:    rkey = bus.sk4;
      4'd5:    rkey = bus.sk5;
      4'd6:    rkey = bus.sk6;
      4'd7:    rkey = bus.sk7;
      4'd8:    rkey = bus.sk8;
      4'd9:    rkey = bus.sk9;
      4'd10:   rkey = bus.sk10;
      default: rkey = bus.sk0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  always_comb begin
    fsm_nxt = fsm;
    accept  = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (fsm)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          fsm_nxt = RUN;
        end
      end
      RUN: begin
        if (rnd == 4'd10) begin
          finish  = 1'b1;
          fsm_nxt = IDLE;
        end else begin
          advance = 1'b1;
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // The final round skips MixColumns and lands directly in the result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      rnd     <= '0;
      done_q  <= 1'b0;
      ct_q    <= '0;
    end else begin
      done_q <= finish;
      if (accept) begin
        state_q <= bus.plaintext ^ bus.sk0;
        rnd     <= 4'd1;
      end else if (advance) begin
        state_q <= mc ^ rkey;
        rnd     <= rnd + 4'd1;
      end else if (finish) begin
        ct_q <= sr ^ rkey;
        rnd  <= 4'd0;
      end
    end
  end

  assign bus.busy       = (fsm == RUN);
  assign bus.done       = done_q;
  assign bus.ciphertext = ct_q;
endmodule

// File: tb/tb_aes_128_encrypt_iter.sv
// Directed bench for the iterative AES-128 core using the FIPS-197 vectors.
// Round keys are expanded here from an independently derived S-box.
module tb_aes_128_encrypt_iter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  localparam logic [127:0] KEYB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEYC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PTC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CTC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [7:0] bsb [256];

  aes_128_encrypt_iter_if bus ();

  aes_128_encrypt_iter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from the multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      end
      bsb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] roundKey(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {bsb[t[31:24]], bsb[t[23:16]], bsb[t[15:8]], bsb[t[7:0]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic loadKeys(input logic [127:0] key);
    bus.sk0  = roundKey(key, 0);
    bus.sk1  = roundKey(key, 1);
    bus.sk2  = roundKey(key, 2);
    bus.sk3  = roundKey(key, 3);
    bus.sk4  = roundKey(key, 4);
    bus.sk5  = roundKey(key, 5);
    bus.sk6  = roundKey(key, 6);
    bus.sk7  = roundKey(key, 7);
    bus.sk8  = roundKey(key, 8);
    bus.sk9  = roundKey(key, 9);
    bus.sk10 = roundKey(key, 10);
  endtask

  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt);
    loadKeys(key);
    bus.plaintext = pt;
    bus.start     = 1'b1;
  endtask

  // Called just after the accepting edge; lat counts edges until done is visible.
  task automatic waitDone(output int lat, output int busyCnt);
    lat     = 99;
    busyCnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) begin
        lat = c;
        break;
      end
      if (bus.busy) busyCnt++;
      @(negedge clk);
    end
  endtask

  task automatic countDone(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
  endtask

  initial begin
    int lat;
    int busyCnt;
    int n;
    logic [127:0] prevCt;
    total = 0;
    bad   = 0;
    buildSbox();
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.plaintext = '0;
    loadKeys(KEYB);

    #17;
    checkOutput("reset_busy", 128'(bus.busy), 128'd0);
    checkOutput("reset_done", 128'(bus.done), 128'd0);
    checkOutput("reset_ct", bus.ciphertext, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] App. B single block");
    applyStimulus(KEYB, PTB);
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(lat, busyCnt);
    checkOutput("b_latency", 128'(lat), 128'd10);
    checkOutput("b_busy_cycles", 128'(busyCnt), 128'd10);
    checkOutput("b_ct", bus.ciphertext, CTB);
    checkOutput("b_busy_in_done", 128'(bus.busy), 128'd0);
    @(negedge clk);
    checkOutput("b_done_width", 128'(bus.done), 128'd0);
    checkOutput("b_ct_hold", bus.ciphertext, CTB);

    $display("[TB] App. C.1 single block");
    applyStimulus(KEYC, PTC);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("c_ct_before_done", bus.ciphertext, CTB);
    waitDone(lat, busyCnt);
    checkOutput("c_latency", 128'(lat), 128'd10);
    checkOutput("c_ct", bus.ciphertext, CTC);
    @(negedge clk);

    $display("[TB] back-to-back with start held");
    applyStimulus(KEYB, PTB);
    @(negedge clk);
    waitDone(lat, busyCnt);
    checkOutput("bb1_latency", 128'(lat), 128'd10);
    checkOutput("bb1_ct", bus.ciphertext, CTB);
    checkOutput("bb1_busy_in_done", 128'(bus.busy), 128'd0);
    loadKeys(KEYC);
    bus.plaintext = PTC;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("bb2_accepted", 128'(bus.busy), 128'd1);
    checkOutput("bb2_done_low", 128'(bus.done), 128'd0);
    checkOutput("bb2_ct_kept", bus.ciphertext, CTB);
    waitDone(lat, busyCnt);
    checkOutput("bb2_latency", 128'(lat), 128'd10);
    checkOutput("bb2_ct", bus.ciphertext, CTC);
    @(negedge clk);

    $display("[TB] start ignored while busy");
    applyStimulus(KEYB, PTB);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.plaintext = PTC;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(lat, busyCnt);
    checkOutput("ign_latency", 128'(lat), 128'd5);
    checkOutput("ign_ct", bus.ciphertext, CTB);
    countDone(15, n);
    checkOutput("ign_single_done", 128'(n), 128'd0);
    checkOutput("ign_no_queue", 128'(bus.busy), 128'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(KEYC, PTC);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 128'(bus.busy), 128'd0);
    checkOutput("rst_done", 128'(bus.done), 128'd0);
    checkOutput("rst_ct", bus.ciphertext, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    countDone(15, n);
    checkOutput("rst_no_done", 128'(n), 128'd0);
    checkOutput("rst_idle", 128'(bus.busy), 128'd0);
    applyStimulus(KEYC, PTC);
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(lat, busyCnt);
    checkOutput("rst_new_latency", 128'(lat), 128'd10);
    checkOutput("rst_new_ct", bus.ciphertext, CTC);

    $display("[TB] random gaps between starts");
    prevCt = CTC;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("gap_done_width", 128'(bus.done), 128'd0);
      repeat ($urandom_range(0, 4)) begin
        checkOutput("gap_ct_stable", bus.ciphertext, prevCt);
        @(negedge clk);
      end
      if (k % 2 == 0) applyStimulus(KEYB, PTB);
      else applyStimulus(KEYC, PTC);
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("gap_ct_busy", bus.ciphertext, prevCt);
      waitDone(lat, busyCnt);
      prevCt = (k % 2 == 0) ? CTB : CTC;
      checkOutput("gap_latency", 128'(lat), 128'd10);
      checkOutput("gap_ct", bus.ciphertext, prevCt);
    end
    @(negedge clk);
    checkOutput("gap_last_done_width", 128'(bus.done), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
